// File: rtl/fir_mac_sequencer_pkg.sv
// rtl/fir_mac_sequencer_pkg.sv - shared widths, state encodings and clog2 for the FIR MAC sequencer
package fir_mac_sequencer_pkg;

  localparam int DEF_WIN      = 16;
  localparam int DEF_WC       = 16;
  localparam int DEF_WOUT     = 16;
  localparam int DEF_NUM_COEF = 17;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int DEF_SEL_W  = clog2(DEF_NUM_COEF);
  localparam int DEF_PROD_W = DEF_WIN + DEF_WC;
  localparam int DEF_ACC_W  = DEF_PROD_W + DEF_SEL_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/fir_mac_dp.sv
// rtl/fir_mac_dp.sv - FIR MAC datapath: product register, accumulator, scale/saturate, output register
module fir_mac_dp
  import fir_mac_sequencer_pkg::*;
#(
  parameter int WIN      = DEF_WIN,
  parameter int WC       = DEF_WC,
  parameter int WOUT     = DEF_WOUT,
  parameter int NUM_COEF = DEF_NUM_COEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIN-1:0]  tap,
  input  logic [WC-1:0]   coef,
  input  logic            prod_en,
  input  logic            acc_load,
  input  logic            acc_add,
  input  logic            out_en,
  output logic [WOUT-1:0] dout,
  output logic            dout_valid
);

  localparam int PROD_W = WIN + WC;
  localparam int ACC_W  = PROD_W + clog2(NUM_COEF);

  logic signed [PROD_W-1:0] tap_ext, coef_ext, prod_d, prod_q;
  logic signed [ACC_W-1:0]  prod_acc, acc_sum, acc_d, acc_q, scaled;
  logic [ACC_W-WOUT:0]      scaled_hi;
  logic [WOUT-1:0]          dout_d, dout_q;
  logic                     dout_valid_q;

  always_comb begin
    tap_ext  = PROD_W'($signed(tap));
    coef_ext = PROD_W'($signed(coef));
    prod_d   = tap_ext * coef_ext;
    prod_acc = ACC_W'(prod_q);
    acc_sum  = acc_q + prod_acc;

    acc_d = acc_q;
    if (acc_load) begin
      acc_d = prod_acc;
    end else if (acc_add) begin
      acc_d = acc_sum;
    end

    // The output is taken from the final accumulate itself, so it lands in the same edge as acc.
    scaled    = acc_sum >>> (WC - 1);
    scaled_hi = scaled[ACC_W-1:WOUT-1];
    if ((scaled_hi == '0) || (scaled_hi == '1)) begin
      dout_d = scaled[WOUT-1:0];
    end else if (scaled[ACC_W-1]) begin
      dout_d = {1'b1, {(WOUT-1){1'b0}}};
    end else begin
      dout_d = {1'b0, {(WOUT-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q       <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (prod_en) prod_q <= prod_d;
      acc_q        <= acc_d;
      if (out_en) dout_q <= dout_d;
      dout_valid_q <= out_en;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - FIR read-side sequencer: sample handshake, tap walk and MAC strobes
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int WIN      = DEF_WIN,
  parameter int WC       = DEF_WC,
  parameter int WOUT     = DEF_WOUT,
  parameter int NUM_COEF = DEF_NUM_COEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIN-1:0]             din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [WIN-1:0]             shift_din,
  output logic                       shift_ce,
  output logic [clog2(NUM_COEF)-1:0] sel,
  input  logic [WIN-1:0]             tap,
  input  logic [WC-1:0]              coef,
  output logic [WOUT-1:0]            dout,
  output logic                       dout_valid,
  output logic                       overrun
);

  localparam int               SEL_W    = clog2(NUM_COEF);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_COEF - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIN-1:0]   shift_din_q, shift_din_d;
  logic             drain_q, drain_d;
  logic             issue, issue_first, issue_last;
  logic             mul_en_q, mul_first_q, mul_last_q;
  logic             acc_en_q, acc_first_q, acc_last_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shift_din_d = shift_din_q;
    drain_d     = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          shift_din_d = din;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sel_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sel_q == SEL_LAST) begin
          drain_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Each issued address travels two stages: read/multiply, then accumulate.
  assign issue       = (state_q == ST_RUN);
  assign issue_first = issue && (sel_q == '0);
  assign issue_last  = issue && (sel_q == SEL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      shift_din_q <= '0;
      drain_q     <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_first_q <= 1'b0;
      mul_last_q  <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shift_din_q <= shift_din_d;
      drain_q     <= drain_d;
      mul_en_q    <= issue;
      mul_first_q <= issue_first;
      mul_last_q  <= issue_last;
      acc_en_q    <= mul_en_q;
      acc_first_q <= mul_first_q;
      acc_last_q  <= mul_last_q;
    end
  end

  assign din_ready = (state_q == ST_IDLE);
  assign shift_ce  = (state_q == ST_SHIFT);
  assign overrun   = din_valid && (state_q != ST_IDLE);
  assign sel       = sel_q;
  assign shift_din = shift_din_q;

  fir_mac_dp #(
    .WIN      (WIN),
    .WC       (WC),
    .WOUT     (WOUT),
    .NUM_COEF (NUM_COEF)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .tap        (tap),
    .coef       (coef),
    .prod_en    (mul_en_q),
    .acc_load   (acc_en_q && acc_first_q),
    .acc_add    (acc_en_q && !acc_first_q),
    .out_en     (acc_en_q && acc_last_q),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for fir_mac_sequencer with delay-line and ROM models
module tb_fir_mac_sequencer;

  localparam int N = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, shift_ce, dout_valid, overrun;
  logic [15:0] shift_din, tap, coef, dout;
  logic [4:0]  sel;

  always #5 clk = ~clk;

  fir_mac_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .shift_din  (shift_din),
    .shift_ce   (shift_ce),
    .sel        (sel),
    .tap        (tap),
    .coef       (coef),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

  // Delay line (sel 0 = oldest) and coefficient ROM, both with one-cycle registered reads
  logic [15:0]        line_q [N];
  logic signed [15:0] rom [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) line_q[i] <= '0;
      tap  <= '0;
      coef <= '0;
    end else begin
      tap  <= line_q[sel];
      coef <= rom[sel];
      if (shift_ce) begin
        for (int i = 0; i < N - 1; i++) line_q[i] <= line_q[i + 1];
        line_q[N - 1] <= shift_din;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: direct-form FIR over the history of accepted samples
  int hist[$];

  function automatic logic [15:0] ref_out();
    longint y;
    int     len;
    y   = 0;
    len = hist.size();
    for (int j = 0; j < N; j++) begin
      if (len - N + j >= 0) y += longint'(hist[len - N + j]) * longint'(rom[j]);
    end
    y = y >>> 15;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return 16'(y);
  endfunction

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         age = -1;
  int         acc_cnt = 0;
  int         shift_cnt = 0;
  int         ovr_cnt = 0;
  int         out_cnt = 0;
  int         const_exp = -1;
  logic [4:0] sel_exp = '0;

  always @(negedge clk) begin
    bit exp_ready;
    int a;
    cyc++;
    if (rst) begin
      chk("rst_din_ready", din_ready, 1);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_shift_ce", shift_ce, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_dout", dout, 0);
      chk("rst_sel", sel, 0);
      chk("rst_shift_din", shift_din, 0);
      sbq.delete();
      hist.delete();
      age = -1;
      sel_exp = '0;
    end else begin
      a = age;
      exp_ready = !(a >= 1 && a <= 20);
      if (a >= 2 && a <= 18) sel_exp = 5'(a - 2);
      chk("din_ready", din_ready, exp_ready);
      chk("shift_ce", shift_ce, a == 1);
      chk("overrun", overrun, din_valid && !exp_ready);
      chk("sel", sel, sel_exp);
      if (shift_ce) shift_cnt++;
      if (overrun) ovr_cnt++;
      if (dout_valid) begin
        out_cnt++;
        if (sbq.size() == 0) begin
          chk("dout_valid_unexpected", 1, 0);
        end else begin
          chk("dout_latency", cyc, sbq[0].due);
          chk("dout", dout, sbq[0].val);
          if (const_exp >= 0) chk("dout_const", dout, const_exp);
          void'(sbq.pop_front());
        end
      end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk("dout_valid_missing", 0, 1);
        void'(sbq.pop_front());
      end
      if (din_valid && exp_ready) begin
        hist.push_back(int'($signed(din)));
        sbq.push_back('{ref_out(), cyc + 21});
        acc_cnt++;
        age = 1;
      end else if (age >= 1) begin
        age = (age >= 21) ? -1 : age + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    int start;
    int budget;
    start  = acc_cnt;
    budget = 60;
    din       = s;
    din_valid = 1'b1;
    do begin
      tick();
      budget--;
    end while (acc_cnt == start && budget > 0);
    din_valid = 1'b0;
    chk("send_accept", acc_cnt - start, 1);
  endtask

  task automatic wait_idle();
    repeat (25) tick();
  endtask

  int base_ovr, base_shift, base_out, base_acc, budget;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int j = 0; j < N; j++) rom[j] = 16'sh4000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Impulse through uniform half-scale coefficients
    base_out  = out_cnt;
    const_exp = 16'h3FFF;
    send(16'h7FFF);
    repeat (16) send(16'h0000);
    wait_idle();
    const_exp = -1;
    chk("impulse_outputs", out_cnt - base_out, 17);

    // Positive saturation
    for (int j = 0; j < N; j++) rom[j] = 16'sh7FFF;
    repeat (17) send(16'h7FFF);
    const_exp = 16'h7FFF;
    repeat (4) send(16'h7FFF);
    wait_idle();
    const_exp = -1;

    // Negative saturation
    repeat (17) send(16'h8000);
    const_exp = 16'h8000;
    repeat (4) send(16'h8000);
    wait_idle();
    const_exp = -1;

    // Overrun: one pulse five cycles after acceptance is dropped
    for (int j = 0; j < N; j++) rom[j] = 16'($urandom_range(0, 8191)) - 16'sd4096;
    base_ovr   = ovr_cnt;
    base_shift = shift_cnt;
    send(16'($urandom));
    repeat (4) tick();
    din       = 16'($urandom);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    wait_idle();
    chk("overrun_pulses", ovr_cnt - base_ovr, 1);
    chk("overrun_shift_ce", shift_cnt - base_shift, 1);
    send(16'($urandom));
    wait_idle();
    chk("after_overrun_shift_ce", shift_cnt - base_shift, 2);

    // Reset in the middle of the tap walk
    send(16'($urandom));
    repeat (9) tick();
    chk("mid_run_sel", sel, 8);
    base_out = out_cnt;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    wait_idle();
    chk("reset_no_dout", out_cnt - base_out, 0);
    send(16'($urandom));
    wait_idle();
    chk("post_reset_dout", out_cnt - base_out, 1);

    // Random back-to-back traffic
    for (int j = 0; j < N; j++) rom[j] = 16'($urandom_range(0, 8191)) - 16'sd4096;
    base_acc  = acc_cnt;
    base_out  = out_cnt;
    budget    = 500 * 25;
    din       = 16'($urandom);
    din_valid = 1'b1;
    while (acc_cnt < base_acc + 500 && budget > 0) begin
      tick();
      din = 16'($urandom);
      budget--;
    end
    din_valid = 1'b0;
    wait_idle();
    chk("random_accepted", acc_cnt - base_acc, 500);
    chk("random_outputs", out_cnt - base_out, 500);

    chk("scoreboard_empty", sbq.size(), 0);
    chk("shift_ce_vs_accepted", shift_cnt, acc_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
